// File: rtl/apb_mem_responder.sv
// APB completer serving a byte-strobed scratch memory window; APB_MEM_RESPONDER_ERR_EN enables pslverr on bad addresses.
// Latency: pready is high 2+WAIT_CYCLES cycles after SETUP; all response outputs are registered.
// Backpressure: wait states via pready only; dropping psel before RESP aborts the transfer without writing.
package dhs_apb_pkg;
  localparam int DHS_ADDRW = 32;
  localparam int DHS_DATAW = 32;

  typedef struct packed {
    logic                   psel;
    logic                   penable;
    logic [DHS_ADDRW-1:0]   paddr;
    logic                   pwrite;
    logic [DHS_DATAW-1:0]   pwdata;
    logic [DHS_DATAW/8-1:0] pstrb;
  } dhs_apb_req_t;

  typedef struct packed {
    logic                 pready;
    logic [DHS_DATAW-1:0] prdata;
    logic                 pslverr;
  } dhs_apb_resp_t;
endpackage

module apb_mem_responder #(
  parameter int                    ADDR_WIDTH  = dhs_apb_pkg::DHS_ADDRW,
  parameter int                    DATA_WIDTH  = dhs_apb_pkg::DHS_DATAW,
  parameter type                   req_t       = dhs_apb_pkg::dhs_apb_req_t,
  parameter type                   resp_t      = dhs_apb_pkg::dhs_apb_resp_t,
  parameter logic [ADDR_WIDTH-1:0] MEM_BASE    = '0,
  parameter int                    MEM_SIZE    = 12,
  parameter int                    WAIT_CYCLES = 0
) (
  input  logic  clk_i,
  input  logic  arst_ni,
  input  req_t  req_i,
  output resp_t resp_o
);

  localparam int STRBW = DATA_WIDTH / 8;
  localparam int OFFW  = $clog2(STRBW);
  localparam int IDXW  = MEM_SIZE - OFFW;
  localparam int DEPTH = 2 ** IDXW;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [IDXW-1:0]         idx_q;
  logic                    wr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRBW-1:0]        strb_q;
  logic                    ill_q;
  logic                    pready_q, pready_d;
  logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
  logic                    pslverr_q, pslverr_d;
  logic                    capture;
  logic                    commit;
  logic                    illegal;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

`ifdef APB_MEM_RESPONDER_ERR_EN
  // MEM_BASE is window-aligned, so the range test reduces to matching the upper address bits.
  assign illegal = (req_i.paddr[ADDR_WIDTH-1:MEM_SIZE] != MEM_BASE[ADDR_WIDTH-1:MEM_SIZE]) ||
                   (req_i.paddr[OFFW-1:0] != '0);
`else
  logic unused_addr_bits;
  assign illegal          = 1'b0;
  assign unused_addr_bits = ^{req_i.paddr[ADDR_WIDTH-1:MEM_SIZE], req_i.paddr[OFFW-1:0]};
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture   = 1'b0;
    commit    = 1'b0;
    pready_d  = 1'b0;
    prdata_d  = '0;
    pslverr_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_i.psel && !req_i.penable) begin
          capture = 1'b1;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!req_i.psel) begin
          state_d = IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          commit    = 1'b1;
          state_d   = RESP;
          pready_d  = 1'b1;
          pslverr_d = ill_q;
          prdata_d  = (!wr_q && !ill_q) ? mem[idx_q] : '0;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      ill_q     <= 1'b0;
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
      if (capture) begin
        idx_q   <= req_i.paddr[MEM_SIZE-1:OFFW];
        wr_q    <= req_i.pwrite;
        wdata_q <= req_i.pwdata;
        strb_q  <= req_i.pstrb;
        ill_q   <= illegal;
      end
    end
  end

  // Storage is not reset; commit is gated by state_q, which reset forces to IDLE.
  always_ff @(posedge clk_i) begin
    if (commit && wr_q && !ill_q) begin
      for (int b = 0; b < STRBW; b++) begin
        if (strb_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign resp_o.pready  = pready_q;
  assign resp_o.prdata  = prdata_q;
  assign resp_o.pslverr = pslverr_q;

endmodule

// File: doc/apb_mem_responder.md
# apb_mem_responder

APB completer that exposes a word-organised, byte-strobed scratch memory at a fixed address window. It is the responding end for the APB initiator that drives `apb_slv_req_i` and loads program images word by word, and it serves as the reference APB target for SoC-level and block-level benches. A registered state machine paces every transfer with a programmable number of wait states, commits writes exactly once, and reports `pslverr` for illegal accesses.

## Interface
- `req_t`, `dhs_apb_req_t`: APB request struct (`psel`, `penable`, `paddr`, `pwrite`, `pwdata`, `pstrb`).
- `resp_t`, `dhs_apb_resp_t`: APB response struct (`pready`, `prdata`, `pslverr`).
- `ADDR_WIDTH`, `DHS_ADDRW`: address width.
- `DATA_WIDTH`, `DHS_DATAW`: data width, 32 or 64.
- `MEM_BASE`, `'0`: byte address of the window start. Must be aligned to `2**MEM_SIZE`.
- `MEM_SIZE`, `12`: log2 of the window size in bytes.
- `WAIT_CYCLES`, `0`: extra ACCESS cycles inserted before `pready`. Range is 0–15.

- `clk_i`: input, 1 bit. The only clock.
- `arst_ni`: input, 1 bit. Asynchronous, active-low reset.
- `req_i`: input, `req_t`. APB request.
- `resp_o`: output, `resp_t`. APB response.

## Operation
- Storage:
  - `2**MEM_SIZE / (DATA_WIDTH/8)` words.
  - Contents are not reset.
  - Word index = `(paddr - MEM_BASE) >> log2(DATA_WIDTH/8)`.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On `psel & !penable` (SETUP), capture `paddr`, `pwrite`, `pwdata`, `pstrb` and the legality flag.
  - Load the counter with `WAIT_CYCLES`, then go to WAIT.
  - `psel & penable` while in IDLE (a protocol violation) is ignored.
- WAIT:
  - If `!psel`, the transfer is aborted: go to IDLE, no write, no response.
  - Otherwise, if the counter is nonzero, decrement it.
  - Otherwise, commit: a legal write updates only the bytes whose `pstrb` bit is set. A read latches the addressed word. Then go to RESP.
- RESP:
  - `pready=1`.
  - `prdata` = latched word for a legal read, 0 for a write or an illegal access.
  - `pslverr` = illegal flag.
  - Go to IDLE unconditionally after one cycle. The transfer completes when `psel & penable & pready`.
- Legality is computed from the SETUP-cycle address only. Changes to `paddr`, `pwdata` or `pstrb` after SETUP are ignored.
- `pstrb=0` on a write: treated as a legal write that changes nothing. `pslverr=0`.

## Timing
- Reset values: state IDLE, `pready=0`, `prdata=0`, `pslverr=0`, counter 0. All response outputs are registered.
- With SETUP in cycle T:
  - `pready` is high in cycle T+2+WAIT_CYCLES.
  - The minimum is one wait state (WAIT_CYCLES=0 → ACCESS lasts 2 cycles).
- Write data is visible to a read whose SETUP is in cycle T+3+WAIT_CYCLES or later.
- Back-to-back transfers: a new SETUP in the cycle after RESP is accepted, with no idle cycle required.
- Outside RESP, `pready`, `prdata` and `pslverr` are all 0.
- Reset asserted mid-transfer: immediate return to IDLE and outputs go to their reset values.
  - If the commit edge has not occurred, the write is discarded.
  - A write already committed stays in memory.
- Reset and SETUP in the same cycle: reset wins, and the transfer is not captured.

## Configuration
- Macro `APB_MEM_RESPONDER_ERR_EN`.
- Defined:
  - An access is illegal if `paddr` is outside `[MEM_BASE, MEM_BASE+2**MEM_SIZE)` or `paddr[log2(DATA_WIDTH/8)-1:0] != 0`.
  - An illegal access gets `pslverr=1` and `prdata=0`, and memory is untouched.
- Undefined:
  - No access is illegal. The offset is masked to `MEM_SIZE` bits (aliasing/wrap-around) and the low byte-offset bits are ignored.
  - `pslverr` is tied 0.

## Test plan
Bench configuration for all scenarios: `MEM_BASE='h1000_0000`, `MEM_SIZE=12`, `DATA_WIDTH=32`, `WAIT_CYCLES=2`.

1. Write `'h1000_0010`←`'hDEAD_BEEF` (`pstrb=4'hF`), then read `'h1000_0010` → `prdata='hDEAD_BEEF`, `pslverr=0`, `pready` in T+4 for each transfer.
2. Write `'h1000_0010`←`'h1122_3344` with `pstrb=4'b0101` over `'hDEAD_BEEF`, then read → `'hDE22_BE44`.
3. With `APB_MEM_RESPONDER_ERR_EN`: write `'h1000_1000` and read `'h1000_0002` → `pslverr=1`, `prdata=0`, and a read of `'h1000_0000` is unchanged. Without the macro: a write to `'h1000_1000` aliases to offset 0, and a read of `'h1000_0000` returns the written data with `pslverr=0`.
4. Drop `psel` in the cycle after SETUP of a write `'h1000_0020`←`'hCAFE_F00D` → no `pready`, and a later read of `'h1000_0020` returns the prior value.
5. Assert `arst_ni=0` during WAIT of a write → `pready`, `prdata` and `pslverr` go to 0 immediately, and the FSM accepts a fresh SETUP one cycle after release.
6. 256 back-to-back writes of `i*'h0101_0101` to consecutive words, then read-back → all match, with no gaps beyond `WAIT_CYCLES+1` per transfer.
